// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } md_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int ITER_W = 6;

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Execute-stage RV32M unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with a single sign-fixup cycle before the result is presented.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_valid_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic            flush_e,
    output logic            md_stall,
    output logic [XLEN-1:0] md_result,
    output logic            md_done,
    output logic            md_busy
);

    localparam logic [ITER_W-1:0] CNT_LAST = ITER_W'(ITER - 1);
    localparam logic [XLEN-1:0]   SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide_if(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    md_state_t           state_q, state_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic                neg_q, neg_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                go, is_div, b_zero, ovf, special;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     abs_a, abs_b, special_res;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;

    // Accept-cycle decode: special cases bypass iteration and go straight to DONE.
    always_comb begin
        go      = (state_q == IDLE) && md_valid_e && !flush_e;
        is_div  = funct3_e[2];
        b_zero  = (src_b_e == '0);
        ovf     = is_div && !funct3_e[0] && (src_a_e == SMIN) && (src_b_e == '1);
        special = is_div && (b_zero || ovf);
        if (b_zero) begin
            special_res = funct3_e[1] ? src_a_e : '1;
        end else begin
            special_res = funct3_e[1] ? '0 : SMIN;
        end
        a_neg = a_is_signed(funct3_e) && src_a_e[XLEN-1];
        b_neg = b_is_signed(funct3_e) && src_b_e[XLEN-1];
        abs_a = neg_if(src_a_e, a_neg);
        abs_b = neg_if(src_b_e, b_neg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = special ? DONE : (is_div ? DIV : MUL);
                end
            end
            MUL, DIV: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIXUP;
                end
            end
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_e) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        md_busy  = (state_q != IDLE);
        md_done  = (state_q == DONE) && !flush_e;
        md_stall = !flush_e &&
                   (((state_q == IDLE) && md_valid_e) ||
                    (state_q == MUL) || (state_q == DIV) || (state_q == FIXUP));
        md_result = result_q;
    end

    // Datapath: acc holds multiplier/product for MUL, dividend/quotient (low half) for DIV.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        f3_d     = f3_q;
        result_d = result_q;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod_fix  = neg_wide_if(acc_q, neg_q);
        quo_fix   = neg_if(acc_q[XLEN-1:0], neg_q);
        rem_fix   = neg_if(rem_q, neg_q);

        case (state_q)
            IDLE: begin
                if (go) begin
                    f3_d  = funct3_e;
                    neg_d = (is_div && funct3_e[1]) ? a_neg : (a_neg ^ b_neg);
                    cnt_d = '0;
                    rem_d = '0;
                    if (special) begin
                        result_d = special_res;
                    end else if (is_div) begin
                        opnd_d = abs_b;
                        acc_d  = {{XLEN{1'b0}}, abs_a};
                    end else begin
                        opnd_d = abs_a;
                        acc_d  = {{XLEN{1'b0}}, abs_b};
                    end
                end
            end
            MUL: begin
                acc_d = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + ITER_W'(1);
            end
            DIV: begin
                // Negative trial difference means the divisor did not fit: restore.
                if (!div_diff[XLEN]) begin
                    rem_d             = div_diff[XLEN-1:0];
                    acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d             = div_shift[XLEN-1:0];
                    acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], 1'b0};
                end
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + ITER_W'(1);
            end
            FIXUP: begin
                case (f3_q)
                    F3_MUL:                      result_d = prod_fix[XLEN-1:0];
                    F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                    F3_DIV, F3_DIVU:             result_d = quo_fix;
                    default:                     result_d = rem_fix;
                endcase
            end
            default: ;
        endcase

        if (flush_e) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            f3_q     <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            f3_q     <= f3_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M cases, special cases,
// flush and reset recovery, then randomized operations against an arithmetic model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_valid_e;
    logic [2:0]  funct3_e;
    logic [31:0] src_a_e;
    logic [31:0] src_b_e;
    logic        flush_e;
    logic        md_stall;
    logic [31:0] md_result;
    logic        md_done;
    logic        md_busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_valid_e (md_valid_e),
        .funct3_e   (funct3_e),
        .src_a_e    (src_a_e),
        .src_b_e    (src_b_e),
        .flush_e    (flush_e),
        .md_stall   (md_stall),
        .md_result  (md_result),
        .md_done    (md_done),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        int ia, ib;
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'd0, a}; ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int exp_stalls(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    // Issue one instruction, hold it in E while stalled, check stall count and busy drop.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int  n;
        bit  seen;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        md_valid_e = 1'b1; funct3_e = f3; src_a_e = a; src_b_e = b;
        n = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (md_done) begin
                seen = 1;
                chk("stall_at_done", {31'd0, md_stall}, 32'd0);
            end else if (md_stall) begin
                n++;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("stall_cycles", n, exp_stalls(f3, a, b));
        @(posedge clk); #1;
        md_valid_e = 1'b0;
        chk("busy_after_done", {31'd0, md_busy}, 32'd0);
    endtask

    // Monitor: every md_done must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && md_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {31'd0, md_done}, 32'd0);
                end else begin
                    chk("result", md_result, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          sel;

        rst_n = 1'b0; md_valid_e = 1'b0; funct3_e = '0;
        src_a_e = '0; src_b_e = '0; flush_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, md_done}, 32'd0);
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_result", md_result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_stall", {31'd0, md_stall}, 32'd0);

        issue(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        issue(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        issue(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
        issue(3'b100, 32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD);
        issue(3'b110, 32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE);
        issue(3'b101, 32'd100,        32'd7,         32'd14);
        issue(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF);
        issue(3'b110, 32'd5,          32'd0,         32'd5);
        issue(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);

        // Flush a DIV in its tenth cycle: nothing may be produced.
        @(posedge clk); #1;
        md_valid_e = 1'b1; funct3_e = 3'b100; src_a_e = 32'd1000; src_b_e = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        flush_e = 1'b1;
        #1;
        chk("flush_stall", {31'd0, md_stall}, 32'd0);
        chk("flush_done", {31'd0, md_done}, 32'd0);
        @(posedge clk); #1;
        flush_e = 1'b0; md_valid_e = 1'b0;
        chk("flush_idle", {31'd0, md_busy}, 32'd0);
        repeat (40) @(posedge clk);
        issue(3'b000, 32'd3, 32'd4, 32'd12);

        // Asynchronous reset in the middle of a MUL.
        @(posedge clk); #1;
        md_valid_e = 1'b1; funct3_e = 3'b000; src_a_e = 32'd9; src_b_e = 32'd9;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0; md_valid_e = 1'b0;
        #1;
        chk("midrst_done", {31'd0, md_done}, 32'd0);
        chk("midrst_busy", {31'd0, md_busy}, 32'd0);
        chk("midrst_stall", {31'd0, md_stall}, 32'd0);
        chk("midrst_result", md_result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
        chk("post_rst_stall", {31'd0, md_stall}, 32'd0);

        for (int k = 0; k < 40; k++) begin
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'd0;
            if (sel == 1) b = $urandom_range(1, 15);
            if (sel == 2) a = 32'h8000_0000;
            if (sel == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            issue(f3, a, b, ref_md(f3, a, b));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
